// File: rtl/piso_shift_register.sv
// Parallel-in, serial-out shift register for the serial audio transmit path.
// Loads a word on a strobe and shifts it out one bit per shift strobe, with busy/done status.
module piso_shift_register #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             CLOCK_50,
  input  logic             Reset,
  input  logic [WIDTH-1:0] Parallel_Data,
  input  logic             Load_Parallel_Data,
  input  logic             Shift_Flag,
  output logic             Serial_Out,
  output logic             Busy,
  output logic             Word_Done
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             done_q, done_d;

  // Load wins over shift; a load while busy simply restarts the count.
  always_comb begin
    sr_d   = sr_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (Load_Parallel_Data) begin
      sr_d  = Parallel_Data;
      cnt_d = CntW'(WIDTH);
    end else if (Shift_Flag && (cnt_q != '0)) begin
      if (MSB_FIRST) begin
        sr_d = {sr_q[WIDTH-2:0], 1'b0};
      end else begin
        sr_d = {1'b0, sr_q[WIDTH-1:1]};
      end
      cnt_d  = cnt_q - CntW'(1);
      done_d = (cnt_q == CntW'(1));
    end
  end

  always_ff @(posedge CLOCK_50 or negedge Reset) begin
    if (!Reset) begin
      sr_q   <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      sr_q   <= sr_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  // Every output comes straight from a register, so none has a combinational path from an input.
  assign Serial_Out = MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0];
  assign Busy       = (cnt_q != '0);
  assign Word_Done  = done_q;

endmodule

// File: tb/tb_piso_shift_register.sv
// Directed self-checking bench for piso_shift_register: one MSB-first and one LSB-first instance.
module tb_piso_shift_register;

  logic       clk;
  logic       rst_n;
  logic [7:0] d_m, d_l;
  logic       ld_m, sh_m, ld_l, sh_l;
  logic       so_m, busy_m, done_m;
  logic       so_l, busy_l, done_l;
  int         tests;
  int         fails;

  piso_shift_register #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
    .CLOCK_50           (clk),
    .Reset              (rst_n),
    .Parallel_Data      (d_m),
    .Load_Parallel_Data (ld_m),
    .Shift_Flag         (sh_m),
    .Serial_Out         (so_m),
    .Busy               (busy_m),
    .Word_Done          (done_m)
  );

  piso_shift_register #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .CLOCK_50           (clk),
    .Reset              (rst_n),
    .Parallel_Data      (d_l),
    .Load_Parallel_Data (ld_l),
    .Shift_Flag         (sh_l),
    .Serial_Out         (so_l),
    .Busy               (busy_l),
    .Word_Done          (done_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive inputs on the falling edge, then sample 1 time unit after the rising edge.
  task automatic step_m(input logic ld, input logic sh, input logic [7:0] d);
    @(negedge clk);
    ld_m = ld;
    sh_m = sh;
    d_m  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic step_l(input logic ld, input logic sh, input logic [7:0] d);
    @(negedge clk);
    ld_l = ld;
    sh_l = sh;
    d_l  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step_m(1'b1, 1'b0, 8'h41);
      tests++;
      if ({so_m, busy_m, done_m} !== 3'b000) begin
        fails++;
        $display("FAIL reset_m[%0d]: so/busy/done got %b want 000", i, {so_m, busy_m, done_m});
      end
      tests++;
      if ({so_l, busy_l, done_l} !== 3'b000) begin
        fails++;
        $display("FAIL reset_l[%0d]: so/busy/done got %b want 000", i, {so_l, busy_l, done_l});
      end
    end
    @(negedge clk);
    ld_m  = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_shift_empty;
    for (int i = 0; i < 2; i++) begin
      step_m(1'b0, (i == 0), 8'h00);
      tests++;
      if ({so_m, busy_m, done_m} !== 3'b000) begin
        fails++;
        $display("FAIL shift_empty[%0d]: so/busy/done got %b want 000", i, {so_m, busy_m, done_m});
      end
    end
  endtask

  task automatic test_serialize;
    logic [7:0] w;
    w = 8'h41;
    step_m(1'b1, 1'b0, w);
    tests++;
    if ({so_m, busy_m, done_m} !== {w[7], 2'b10}) begin
      fails++;
      $display("FAIL ser_load: so/busy/done got %b want %b", {so_m, busy_m, done_m}, {w[7], 2'b10});
    end
    for (int i = 1; i < 8; i++) begin
      step_m(1'b0, 1'b1, 8'h00);
      tests++;
      if ({so_m, busy_m, done_m} !== {w[7-i], 2'b10}) begin
        fails++;
        $display("FAIL ser_bit%0d: so/busy/done got %b want %b", i, {so_m, busy_m, done_m},
                 {w[7-i], 2'b10});
      end
      step_m(1'b0, 1'b0, 8'h00);
      tests++;
      if ({so_m, busy_m, done_m} !== {w[7-i], 2'b10}) begin
        fails++;
        $display("FAIL ser_hold%0d: so/busy/done got %b want %b", i, {so_m, busy_m, done_m},
                 {w[7-i], 2'b10});
      end
    end
    step_m(1'b0, 1'b1, 8'h00);
    tests++;
    if ({so_m, busy_m, done_m} !== 3'b001) begin
      fails++;
      $display("FAIL ser_last: so/busy/done got %b want 001", {so_m, busy_m, done_m});
    end
    step_m(1'b0, 1'b0, 8'h00);
    tests++;
    if ({so_m, busy_m, done_m} !== 3'b000) begin
      fails++;
      $display("FAIL ser_done_pulse: so/busy/done got %b want 000", {so_m, busy_m, done_m});
    end
  endtask

  task automatic test_simultaneous;
    logic [7:0] w;
    w = 8'hA5;
    step_m(1'b1, 1'b1, w);
    tests++;
    if ({so_m, busy_m, done_m} !== 3'b110) begin
      fails++;
      $display("FAIL simul_load: so/busy/done got %b want 110", {so_m, busy_m, done_m});
    end
    // Back-to-back shifts: a full 8 must be needed to empty the word.
    for (int i = 1; i < 8; i++) begin
      step_m(1'b0, 1'b1, 8'h00);
      tests++;
      if ({so_m, busy_m, done_m} !== {w[7-i], 2'b10}) begin
        fails++;
        $display("FAIL simul_bit%0d: so/busy/done got %b want %b", i, {so_m, busy_m, done_m},
                 {w[7-i], 2'b10});
      end
    end
    step_m(1'b0, 1'b1, 8'h00);
    tests++;
    if ({so_m, busy_m, done_m} !== 3'b001) begin
      fails++;
      $display("FAIL simul_last: so/busy/done got %b want 001", {so_m, busy_m, done_m});
    end
    step_m(1'b0, 1'b1, 8'h00);
    tests++;
    if ({so_m, busy_m, done_m} !== 3'b000) begin
      fails++;
      $display("FAIL simul_overshift: so/busy/done got %b want 000", {so_m, busy_m, done_m});
    end
    step_m(1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_reset_mid_word;
    step_m(1'b1, 1'b0, 8'hFF);
    for (int i = 0; i < 3; i++) step_m(1'b0, 1'b1, 8'h00);
    tests++;
    if ({so_m, busy_m, done_m} !== 3'b110) begin
      fails++;
      $display("FAIL midrst_pre: so/busy/done got %b want 110", {so_m, busy_m, done_m});
    end
    sh_m = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({so_m, busy_m, done_m} !== 3'b000) begin
      fails++;
      $display("FAIL midrst_async: so/busy/done got %b want 000", {so_m, busy_m, done_m});
    end
    step_m(1'b0, 1'b0, 8'h00);
    tests++;
    if ({so_m, busy_m, done_m} !== 3'b000) begin
      fails++;
      $display("FAIL midrst_held: so/busy/done got %b want 000", {so_m, busy_m, done_m});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_lsb_reload;
    logic [7:0] w;
    logic [2:0] exp_seq;
    w       = 8'h80;
    exp_seq = 3'b001;  // 0x41 LSB first: 1, 0, 0
    step_l(1'b1, 1'b0, 8'h41);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) step_l(1'b0, 1'b1, 8'h00);
      tests++;
      if ({so_l, busy_l, done_l} !== {exp_seq[i], 2'b10}) begin
        fails++;
        $display("FAIL lsb_bit%0d: so/busy/done got %b want %b", i, {so_l, busy_l, done_l},
                 {exp_seq[i], 2'b10});
      end
    end
    step_l(1'b1, 1'b0, w);
    tests++;
    if ({so_l, busy_l, done_l} !== 3'b010) begin
      fails++;
      $display("FAIL lsb_reload: so/busy/done got %b want 010", {so_l, busy_l, done_l});
    end
    for (int i = 1; i < 8; i++) begin
      step_l(1'b0, 1'b1, 8'h00);
      tests++;
      if ({so_l, busy_l, done_l} !== {w[i], 2'b10}) begin
        fails++;
        $display("FAIL lsb_new_bit%0d: so/busy/done got %b want %b", i, {so_l, busy_l, done_l},
                 {w[i], 2'b10});
      end
    end
    step_l(1'b0, 1'b1, 8'h00);
    tests++;
    if ({so_l, busy_l, done_l} !== 3'b001) begin
      fails++;
      $display("FAIL lsb_last: so/busy/done got %b want 001", {so_l, busy_l, done_l});
    end
    step_l(1'b0, 1'b0, 8'h00);
    tests++;
    if ({so_l, busy_l, done_l} !== 3'b000) begin
      fails++;
      $display("FAIL lsb_done_pulse: so/busy/done got %b want 000", {so_l, busy_l, done_l});
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b1;
    {ld_m, sh_m, ld_l, sh_l} = '0;
    d_m = '0;
    d_l = '0;
    test_reset();
    test_shift_empty();
    test_serialize();
    test_simultaneous();
    test_reset_mid_word();
    test_lsb_reload();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
